// File: rtl/mvm_ctrl_pkg.sv
// Shared sizes, state and opcode encodings for the mvm crossbar controller.
package mvm_ctrl_pkg;

   localparam int N      = 4;
   localparam int XIN_W  = 4;
   localparam int XOUT_W = 8;
   localparam int WT_W   = 4;

   localparam int NN     = N * N;
   localparam int IDX_W  = (NN > 1) ? $clog2(NN) : 1;
   localparam int XIDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WLOAD,
      S_PROG,
      S_XLOAD,
      S_RUN,
      S_DRAIN
   } state_t;

   typedef enum logic {
      OP_RUN  = 1'b0,
      OP_PROG = 1'b1
   } op_t;

endpackage

// File: rtl/mvm_ctrl_if.sv
// Core-side streams of the mvm controller: command, weights, input vector, results, status.
interface mvm_ctrl_if;
   import mvm_ctrl_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   op_t               cmd_op;
   logic              wt_valid;
   logic              wt_ready;
   logic [WT_W-1:0]   wt_data;
   logic              x_valid;
   logic              x_ready;
   logic [XIN_W-1:0]  x_data;
   logic              y_valid;
   logic              y_ready;
   logic [XOUT_W-1:0] y_data;
   logic              y_last;
   logic              busy;
   logic              err_timeout;

   modport slave (
      input  cmd_valid, cmd_op, wt_valid, wt_data, x_valid, x_data, y_ready,
      output cmd_ready, wt_ready, x_ready, y_valid, y_data, y_last, busy, err_timeout
   );

   modport master (
      output cmd_valid, cmd_op, wt_valid, wt_data, x_valid, x_data, y_ready,
      input  cmd_ready, wt_ready, x_ready, y_valid, y_data, y_last, busy, err_timeout
   );

endinterface

// File: rtl/mvm_ctrl.sv
// Initiator for one mvm crossbar: loads weights / input vector, sequences prog and run,
// captures the crossbar result on the mvm_done rising edge and streams it back out.
module mvm_ctrl
   import mvm_ctrl_pkg::*;
#(
   parameter int PROG_CYCLES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic              clk,
   input  logic              reset,
   mvm_ctrl_if.slave         s_if,
   output logic              reset_wt,
   output logic              prog_wt,
   output logic              mvm_start,
   input  logic              mvm_done,
   output logic [XIN_W-1:0]  xbar_input  [N],
   output logic [WT_W-1:0]   wr_weight   [NN],
   input  logic [XOUT_W-1:0] xbar_output [N]
);

   localparam int PCNT_W = $clog2(PROG_CYCLES + 1);
   localparam int TCNT_W = $clog2(TIMEOUT + 1);
   localparam logic [PCNT_W-1:0] PCNT_LAST   = PCNT_W'(PROG_CYCLES - 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST   = TCNT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0]  IDX_WT_LAST = IDX_W'(NN - 1);
   localparam logic [IDX_W-1:0]  IDX_X_LAST  = IDX_W'(N - 1);

   state_t              r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [PCNT_W-1:0]   r_pcnt;
   logic [TCNT_W-1:0]   r_tcnt;
   logic                r_done_q;
   logic                r_err;
   logic                r_cmd_ready;
   logic                r_wt_ready;
   logic                r_x_ready;
   logic                r_y_valid;
   logic                r_prog_wt;
   logic                r_mvm_start;
   logic                r_reset_wt;
   logic [WT_W-1:0]     r_wt_buf [NN];
   logic [XIN_W-1:0]    r_x_buf  [N];
   logic [XOUT_W-1:0]   r_y_buf  [N];

   logic w_cmd_fire, w_wt_fire, w_x_fire, w_y_fire, w_done_rise;

   assign w_cmd_fire  = s_if.cmd_valid & s_if.cmd_ready;
   assign w_wt_fire   = s_if.wt_valid & r_wt_ready;
   assign w_x_fire    = s_if.x_valid & r_x_ready;
   assign w_y_fire    = r_y_valid & s_if.y_ready;
   // A done level left high from an earlier run must not count as completion.
   assign w_done_rise = mvm_done & ~r_done_q;

   always_ff @(posedge clk) begin
      r_reset_wt <= reset;
      r_done_q   <= mvm_done;
      if (reset) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_pcnt      <= '0;
         r_tcnt      <= '0;
         r_err       <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_wt_ready  <= 1'b0;
         r_x_ready   <= 1'b0;
         r_y_valid   <= 1'b0;
         r_prog_wt   <= 1'b0;
         r_mvm_start <= 1'b0;
         for (int i = 0; i < NN; i++) r_wt_buf[i] <= '0;
         for (int i = 0; i < N; i++) begin
            r_x_buf[i] <= '0;
            r_y_buf[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: if (w_cmd_fire) begin
               r_idx       <= '0;
               r_cmd_ready <= 1'b0;
               if (s_if.cmd_op == OP_PROG) begin
                  r_state    <= S_WLOAD;
                  r_wt_ready <= 1'b1;
               end else begin
                  r_state   <= S_XLOAD;
                  r_x_ready <= 1'b1;
               end
            end
            S_WLOAD: if (w_wt_fire) begin
               r_wt_buf[r_idx] <= s_if.wt_data;
               if (r_idx == IDX_WT_LAST) begin
                  r_idx      <= '0;
                  r_wt_ready <= 1'b0;
                  r_prog_wt  <= 1'b1;
                  r_pcnt     <= '0;
                  r_state    <= S_PROG;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_PROG: begin
               if (r_pcnt == PCNT_LAST) begin
                  r_prog_wt   <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_pcnt <= r_pcnt + 1'b1;
               end
            end
            S_XLOAD: if (w_x_fire) begin
               r_x_buf[r_idx[XIDX_W-1:0]] <= s_if.x_data;
               if (r_idx == IDX_X_LAST) begin
                  r_idx       <= '0;
                  r_x_ready   <= 1'b0;
                  r_mvm_start <= 1'b1;
                  r_tcnt      <= '0;
                  r_state     <= S_RUN;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_RUN: begin
               if (w_done_rise) begin
                  r_y_buf     <= xbar_output;
                  r_mvm_start <= 1'b0;
                  r_y_valid   <= 1'b1;
                  r_idx       <= '0;
                  r_state     <= S_DRAIN;
               end else if (r_tcnt == TCNT_LAST) begin
                  r_err       <= 1'b1;
                  r_mvm_start <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
               end
            end
            S_DRAIN: if (w_y_fire) begin
               if (r_idx == IDX_X_LAST) begin
                  r_idx       <= '0;
                  r_y_valid   <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: begin
               r_cmd_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   // Crossbar strobes and cmd_ready are masked by reset so they drop in the reset cycle itself.
   assign s_if.cmd_ready   = r_cmd_ready & ~reset;
   assign prog_wt          = r_prog_wt & ~reset;
   assign mvm_start        = r_mvm_start & ~reset;
   assign reset_wt         = r_reset_wt;
   assign s_if.wt_ready    = r_wt_ready;
   assign s_if.x_ready     = r_x_ready;
   assign s_if.y_valid     = r_y_valid;
   assign s_if.y_data      = r_y_buf[r_idx[XIDX_W-1:0]];
   assign s_if.y_last      = r_y_valid & (r_idx == IDX_X_LAST);
   assign s_if.busy        = (r_state != S_IDLE);
   assign s_if.err_timeout = r_err;
   assign wr_weight        = r_wt_buf;
   assign xbar_input       = r_x_buf;

endmodule

// File: tb/tb_mvm_ctrl.sv
// Directed bench for mvm_ctrl with a behavioural mvm stub and a result scoreboard queue.
module tb_mvm_ctrl;
   import mvm_ctrl_pkg::*;

   localparam int TB_PROG = 2;
   localparam int TB_TMO  = 16;

   logic clk = 1'b0;
   logic reset;
   logic reset_wt, prog_wt, mvm_start, mvm_done;
   logic [XIN_W-1:0]  xbar_input  [N];
   logic [WT_W-1:0]   wr_weight   [NN];
   logic [XOUT_W-1:0] xbar_output [N];

   mvm_ctrl_if bus ();

   mvm_ctrl #(.PROG_CYCLES(TB_PROG), .TIMEOUT(TB_TMO)) dut (
      .clk(clk),
      .reset(reset),
      .s_if(bus),
      .reset_wt(reset_wt),
      .prog_wt(prog_wt),
      .mvm_start(mvm_start),
      .mvm_done(mvm_done),
      .xbar_input(xbar_input),
      .wr_weight(wr_weight),
      .xbar_output(xbar_output)
   );

   always #5 clk = ~clk;

   int vec  = 0;
   int miss = 0;
   int wm [NN];
   int xm [N];
   logic [XOUT_W-1:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send_cmd(input op_t op);
      int g = 0;
      bus.cmd_op    = op;
      bus.cmd_valid = 1'b1;
      while (!bus.cmd_ready && g < 50) begin tick(); g++; end
      if (g >= 50) chk("cmd_wait_bound", g, 0);
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic push_wt(input int d, inout int stalls);
      int g = 0;
      bus.wt_valid = 1'b1;
      bus.wt_data  = WT_W'(d);
      while (!bus.wt_ready && g < 50) begin tick(); g++; end
      if (g >= 50) chk("wt_wait_bound", g, 0);
      stalls += g;
      tick();
      bus.wt_valid = 1'b0;
   endtask

   task automatic push_x(input int d, inout int stalls);
      int g = 0;
      bus.x_valid = 1'b1;
      bus.x_data  = XIN_W'(d);
      while (!bus.x_ready && g < 50) begin tick(); g++; end
      if (g >= 50) chk("x_wait_bound", g, 0);
      stalls += g;
      tick();
      bus.x_valid = 1'b0;
   endtask

   // Behavioural crossbar: dot product of each weight row with the input vector.
   task automatic mvm_eval();
      for (int i = 0; i < N; i++) begin
         int s = 0;
         for (int j = 0; j < N; j++) s += int'(wr_weight[i*N+j]) * int'(xbar_input[j]);
         xbar_output[i] = XOUT_W'(s);
      end
   endtask

   task automatic do_prog();
      int st = 0;
      int pc = 0;
      send_cmd(OP_PROG);
      chk("wt_ready_after_cmd", bus.wt_ready, 1);
      chk("busy_wload", bus.busy, 1);
      chk("cmd_ready_wload", bus.cmd_ready, 0);
      for (int k = 0; k < NN; k++) push_wt(wm[k], st);
      chk("wt_stalls", st, 0);
      chk("wt_ready_prog", bus.wt_ready, 0);
      while (prog_wt && pc < 20) begin pc++; tick(); end
      chk("prog_cycles", pc, TB_PROG);
      chk("cmd_ready_after_prog", bus.cmd_ready, 1);
      chk("busy_after_prog", bus.busy, 0);
      for (int k = 0; k < NN; k++) chk($sformatf("wr_weight[%0d]", k), wr_weight[k], WT_W'(wm[k]));
   endtask

   task automatic do_xload(input bit push_exp);
      int st = 0;
      send_cmd(OP_RUN);
      chk("x_ready_after_cmd", bus.x_ready, 1);
      for (int j = 0; j < N; j++) push_x(xm[j], st);
      chk("x_stalls", st, 0);
      chk("mvm_start_rise", mvm_start, 1);
      chk("x_ready_run", bus.x_ready, 0);
      if (push_exp) begin
         for (int i = 0; i < N; i++) begin
            int s = 0;
            for (int j = 0; j < N; j++) s += wm[i*N+j] * xm[j];
            exp_q.push_back(XOUT_W'(s));
         end
      end
   endtask

   task automatic drain(input bit toggle);
      int got = 0;
      int g = 0;
      bit stalled = 1'b0;
      bit ph = 1'b0;
      logic [XOUT_W-1:0] held = '0;
      while (got < N && g < 100) begin
         bus.y_ready = toggle ? ph : 1'b1;
         ph = ~ph;
         if (bus.y_valid) begin
            if (stalled) chk("y_stable", bus.y_data, held);
            if (exp_q.size() > 0) chk($sformatf("y_data[%0d]", got), bus.y_data, exp_q[0]);
            else chk("y_unexpected", bus.y_data, 'x);
            chk($sformatf("y_last[%0d]", got), bus.y_last, (got == N - 1));
            if (bus.y_ready) begin
               void'(exp_q.pop_front());
               got++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held = bus.y_data;
            end
         end
         tick();
         g++;
      end
      bus.y_ready = 1'b0;
      chk("drain_beats", got, N);
      chk("y_valid_after_drain", bus.y_valid, 0);
      chk("cmd_ready_after_drain", bus.cmd_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit early;
      bit saw;
      int cnt;
      reset = 1'b1;
      mvm_done = 1'b0;
      for (int i = 0; i < N; i++) xbar_output[i] = '0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_RUN;
      bus.wt_valid  = 1'b0;
      bus.wt_data   = '0;
      bus.x_valid   = 1'b0;
      bus.x_data    = '0;
      bus.y_ready   = 1'b0;

      // Power-on reset
      tick();
      chk("rst_reset_wt", reset_wt, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      chk("rst_mvm_start", mvm_start, 0);
      chk("rst_prog_wt", prog_wt, 0);
      chk("rst_y_valid", bus.y_valid, 0);
      chk("rst_wt_ready", bus.wt_ready, 0);
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rel_cmd_ready", bus.cmd_ready, 1);
      chk("rel_reset_wt_late", reset_wt, 1);
      tick();
      chk("rel_reset_wt", reset_wt, 0);
      chk("rel_err", bus.err_timeout, 0);
      chk("rel_wr_weight0", wr_weight[0], 0);

      // Beats offered in IDLE are ignored
      bus.wt_valid = 1'b1; bus.wt_data = WT_W'(7);
      bus.x_valid  = 1'b1; bus.x_data  = XIN_W'(7);
      tick(); tick();
      chk("idle_wt_ready", bus.wt_ready, 0);
      chk("idle_x_ready", bus.x_ready, 0);
      bus.wt_valid = 1'b0;
      bus.x_valid  = 1'b0;

      // PROG all-ones, then RUN with half-ones input
      for (int k = 0; k < NN; k++) wm[k] = 1;
      do_prog();
      for (int j = 0; j < N; j++) xm[j] = (j < N / 2) ? 1 : 0;
      do_xload(1'b1);
      repeat (3) tick();
      chk("no_y_before_done", bus.y_valid, 0);
      mvm_eval();
      mvm_done = 1'b1;
      tick();
      chk("mvm_start_fall", mvm_start, 0);
      chk("y_valid_first", bus.y_valid, 1);
      mvm_done = 1'b0;
      drain(1'b0);

      // Mixed weights, result backpressure toggling every cycle
      for (int k = 0; k < NN; k++) wm[k] = (k % 3) + 1;
      do_prog();
      for (int j = 0; j < N; j++) xm[j] = (j * 7 + 3) % 16;
      do_xload(1'b1);
      repeat (2) tick();
      mvm_eval();
      mvm_done = 1'b1;
      tick();
      mvm_done = 1'b0;
      drain(1'b1);

      // Stale done level entering RUN; capture only on the later rise
      for (int i = 0; i < N; i++) xbar_output[i] = XOUT_W'(8'hAA);
      mvm_done = 1'b1;
      for (int j = 0; j < N; j++) xm[j] = (j * 5 + 5) % 16;
      do_xload(1'b1);
      repeat (5) begin
         tick();
         chk("stale_no_y", bus.y_valid, 0);
      end
      chk("stale_start_held", mvm_start, 1);
      mvm_done = 1'b0;
      tick();
      mvm_eval();
      mvm_done = 1'b1;
      tick();
      chk("stale_y_valid", bus.y_valid, 1);
      mvm_done = 1'b0;
      drain(1'b1);

      // Timeout with done stuck low
      do_xload(1'b0);
      cnt = 0; early = 1'b0; saw = 1'b0;
      while (mvm_start && cnt < 100) begin
         cnt++;
         if (bus.err_timeout) early = 1'b1;
         if (bus.y_valid) saw = 1'b1;
         tick();
      end
      chk("tmo_run_cycles", cnt, TB_TMO);
      chk("tmo_err_early", early, 0);
      chk("tmo_no_y_valid", saw, 0);
      chk("tmo_err_set", bus.err_timeout, 1);
      chk("tmo_idle", bus.busy, 0);
      chk("tmo_cmd_ready", bus.cmd_ready, 1);
      repeat (3) tick();
      chk("tmo_err_sticky", bus.err_timeout, 1);

      // Reset in the middle of RUN
      do_xload(1'b0);
      tick(); tick();
      chk("mid_start_high", mvm_start, 1);
      reset = 1'b1;
      #1;
      chk("mid_start_drop", mvm_start, 0);
      chk("mid_prog_low", prog_wt, 0);
      tick();
      chk("mid_busy", bus.busy, 0);
      chk("mid_err_clear", bus.err_timeout, 0);
      chk("mid_reset_wt", reset_wt, 1);
      chk("mid_start_after", mvm_start, 0);
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("mid_reset_wt_late", reset_wt, 1);
      chk("mid_cmd_ready", bus.cmd_ready, 1);
      tick();
      chk("mid_reset_wt_low", reset_wt, 0);
      chk("mid_wt_cleared", wr_weight[NN-1], 0);
      chk("mid_x_cleared", xbar_input[0], 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
